// File: rtl/sr_row_feeder.sv
// Row-buffered feeder for a DEPTH-stage parallel-out shift register: buffers one row, replays it
// gap-free, and reports the column/row of every complete same-row window on the register's p_out.
module sr_row_feeder #(
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned ROW_LEN = 8,
  parameter int unsigned ROWS    = 8,
  localparam int unsigned ColW   = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1,
  localparam int unsigned RowW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [7:0]      sr_data,
  output logic            window_valid,
  output logic [ColW-1:0] window_col,
  output logic [RowW-1:0] window_row,
  output logic            frame_done
);

  localparam logic [ColW-1:0] LastCol  = ColW'(ROW_LEN - 1);
  localparam logic [ColW-1:0] FirstWin = ColW'(DEPTH - 1);
  localparam logic [ColW-1:0] LastWin  = ColW'(ROW_LEN - DEPTH);
  localparam logic [RowW-1:0] LastRow  = RowW'(ROWS - 1);

  typedef enum logic [0:0] {StFill, StDrain} state_e;

  state_e          state_q, state_d;
  logic [ColW-1:0] wr_ptr_q, wr_ptr_d;
  logic [ColW-1:0] rd_ptr_q, rd_ptr_d;
  logic [RowW-1:0] row_q, row_d;
  logic [7:0]      sr_data_q, sr_data_d;
  logic            sr_vld_q, sr_vld_d;
  logic [ColW-1:0] sr_k_q, sr_k_d;
  logic            win_valid_q, win_valid_d;
  logic [ColW-1:0] win_col_q, win_col_d;
  logic [RowW-1:0] win_row_q, win_row_d;
  logic            frame_done_q, frame_done_d;
  logic            buf_we;
  logic            win_hit;
  logic            row_last;
  logic [7:0]      buf_q [ROW_LEN];

  assign in_ready = (state_q == StFill);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    sr_data_d = 8'h00;
    sr_vld_d  = 1'b0;
    sr_k_d    = rd_ptr_q;
    buf_we    = 1'b0;
    unique case (state_q)
      StFill: begin
        if (in_valid) begin
          buf_we = 1'b1;
          if (wr_ptr_q == LastCol) begin
            wr_ptr_d = '0;
            state_d  = StDrain;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      StDrain: begin
        sr_data_d = buf_q[rd_ptr_q];
        sr_vld_d  = 1'b1;
        if (rd_ptr_q == LastCol) begin
          rd_ptr_d = '0;
          state_d  = StFill;
        end else begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Window stage trails sr_data by one cycle, matching the shift register's own latency.
  always_comb begin
    win_hit      = sr_vld_q && (sr_k_q >= FirstWin);
    row_last     = win_hit && (sr_k_q == LastCol);
    win_valid_d  = win_hit;
    win_col_d    = win_hit ? (sr_k_q - FirstWin) : win_col_q;
    win_row_d    = win_hit ? row_q : win_row_q;
    frame_done_d = row_last && (row_q == LastRow);
    row_d        = row_q;
    if (row_last) begin
      row_d = (row_q == LastRow) ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StFill;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      row_q        <= '0;
      sr_data_q    <= 8'h00;
      sr_vld_q     <= 1'b0;
      sr_k_q       <= '0;
      win_valid_q  <= 1'b0;
      win_col_q    <= '0;
      win_row_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      row_q        <= row_d;
      sr_data_q    <= sr_data_d;
      sr_vld_q     <= sr_vld_d;
      sr_k_q       <= sr_k_d;
      win_valid_q  <= win_valid_d;
      win_col_q    <= win_col_d;
      win_row_q    <= win_row_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clock) begin
    if (buf_we) begin
      buf_q[wr_ptr_q] <= in_data;
    end
  end

  assign sr_data      = sr_data_q;
  assign window_valid = win_valid_q;
  assign window_col   = win_col_q;
  assign window_row   = win_row_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_sr_row_feeder.sv
// Directed bench for sr_row_feeder: models the downstream shift register and checks replay,
// window reporting, row/frame advance, drain-time input blocking and mid-drain reset.
module tb_sr_row_feeder;

  localparam int DEPTH   = 3;
  localparam int ROW_LEN = 8;
  localparam int ROWS    = 2;
  localparam int NWIN    = ROW_LEN - DEPTH + 1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] sr_data;
  logic       window_valid;
  logic [2:0] window_col;
  logic [0:0] window_row;
  logic       frame_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] s1 = 8'h00, s2 = 8'h00, s3 = 8'h00;

  int sr_val[$], sr_cyc[$];
  int w_col[$], w_row[$], w_s1[$], w_s3[$], w_cyc[$];
  int fd_cnt = 0, fd_col = -1, fd_row = -1;

  sr_row_feeder #(.DEPTH(DEPTH), .ROW_LEN(ROW_LEN), .ROWS(ROWS)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sr_data      (sr_data),
    .window_valid (window_valid),
    .window_col   (window_col),
    .window_row   (window_row),
    .frame_done   (frame_done)
  );

  always #5 clock = ~clock;

  // Downstream parallel-out shift register.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    s1  <= sr_data;
    s2  <= s1;
    s3  <= s2;
  end

  always @(negedge clock) begin
    if (reset) begin
      if (sr_data != 8'h00) begin
        sr_val.push_back(int'(sr_data));
        sr_cyc.push_back(cyc);
      end
      if (window_valid) begin
        w_col.push_back(int'(window_col));
        w_row.push_back(int'(window_row));
        w_s1.push_back(int'(s1));
        w_s3.push_back(int'(s3));
        w_cyc.push_back(cyc);
      end
      if (frame_done) begin
        fd_cnt++;
        fd_col = int'(window_col);
        fd_row = int'(window_row);
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill_row(input int base, input bit toggle);
    int  idx = 0;
    int  guard = 0;
    bit  ph = 1'b1;
    bit  acc;
    while (idx < ROW_LEN && guard < 100) begin
      in_valid = toggle ? ph : 1'b1;
      in_data  = 8'(base + idx);
      acc      = in_valid && in_ready;
      tick();
      if (acc) idx++;
      ph = !ph;
      guard++;
    end
    check("accept_all", idx, ROW_LEN);
    check("ready_drop", int'(in_ready), 0);
  endtask

  task automatic drain_wait(input bit junk);
    int n = 0;
    while (!in_ready && n < 40) begin
      in_valid = junk;
      in_data  = 8'hFF;
      tick();
      n++;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    check("drain_len", n, ROW_LEN);
  endtask

  task automatic check_row(input int r, input int base, input int row);
    for (int k = 0; k < ROW_LEN; k++) begin
      check("sr_pixel", sr_val[r*ROW_LEN+k], base + k);
      if (k > 0) check("sr_contig", sr_cyc[r*ROW_LEN+k] - sr_cyc[r*ROW_LEN+k-1], 1);
    end
    for (int j = 0; j < NWIN; j++) begin
      check("win_col", w_col[r*NWIN+j], j);
      check("win_row", w_row[r*NWIN+j], row);
      check("pout_s1", w_s1[r*NWIN+j], base + j + DEPTH - 1);
      check("pout_s3", w_s3[r*NWIN+j], base + j);
      check("win_timing", w_cyc[r*NWIN+j] - sr_cyc[r*ROW_LEN+j+DEPTH-1], 1);
    end
  endtask

  task automatic clear_logs();
    sr_val.delete(); sr_cyc.delete();
    w_col.delete(); w_row.delete(); w_s1.delete(); w_s3.delete(); w_cyc.delete();
    fd_cnt = 0; fd_col = -1; fd_row = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int g;
    #12;
    check("rst_sr_data", int'(sr_data), 0);
    check("rst_win_valid", int'(window_valid), 0);
    check("rst_win_col", int'(window_col), 0);
    check("rst_win_row", int'(window_row), 0);
    check("rst_frame_done", int'(frame_done), 0);
    tick();
    reset = 1'b1;
    tick();
    check("rst_in_ready", int'(in_ready), 1);

    // Continuous row, toggling row with 0xFF pushed during drain, then a third row (frame wrap).
    fill_row(8'h01, 1'b0);
    drain_wait(1'b0);
    fill_row(8'h01, 1'b1);
    drain_wait(1'b1);
    fill_row(8'h21, 1'b0);
    drain_wait(1'b0);
    repeat (6) tick();

    check("sr_count", sr_val.size(), 3 * ROW_LEN);
    check("win_count", w_col.size(), 3 * NWIN);
    if (sr_val.size() == 3 * ROW_LEN && w_col.size() == 3 * NWIN) begin
      check_row(0, 8'h01, 0);
      check_row(1, 8'h01, 1);
      check_row(2, 8'h21, 0);
    end
    check("frame_done_cnt", fd_cnt, 1);
    check("frame_done_col", fd_col, NWIN - 1);
    check("frame_done_row", fd_row, 1);
    check("idle_sr_zero", int'(sr_data), 0);

    // Reset during drain, one cycle after pixel 4 is on sr_data.
    fill_row(8'h31, 1'b0);
    g = 0;
    while (sr_data != 8'h34 && g < 20) begin
      tick();
      g++;
    end
    check("mid_reach_px4", int'(sr_data), 8'h34);
    tick();
    check("pre_rst_win_valid", int'(window_valid), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_sr_data", int'(sr_data), 0);
    check("mid_rst_win_valid", int'(window_valid), 0);
    check("mid_rst_win_col", int'(window_col), 0);
    check("mid_rst_win_row", int'(window_row), 0);
    check("mid_rst_frame_done", int'(frame_done), 0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    clear_logs();

    fill_row(8'h41, 1'b0);
    drain_wait(1'b0);
    repeat (6) tick();
    check("post_sr_count", sr_val.size(), ROW_LEN);
    check("post_win_count", w_col.size(), NWIN);
    if (sr_val.size() == ROW_LEN && w_col.size() == NWIN) check_row(0, 8'h41, 0);
    check("post_frame_done_cnt", fd_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
